// File: rtl/acc_tile_drain.sv
// Ping-pong accumulator tile buffer that drains elements row-major with round/shift requantisation.
// Build option: define ACC_TILE_DRAIN_SAT_EN to clip results to OUT_W (default build wraps).
module acc_tile_drain #(
  parameter int TILE  = 4,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  localparam int IW   = (TILE > 1) ? $clog2(TILE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  acc_valid,
  output logic                  acc_ready,
  input  logic [TILE*ACC_W-1:0] acc_data,
  input  logic [4:0]            cfg_shift,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic [IW-1:0]         out_row,
  output logic [IW-1:0]         out_col,
  output logic                  out_last,
  output logic                  out_sat
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t r_state, w_state_nxt;

  logic [1:0][TILE-1:0][TILE-1:0][ACC_W-1:0] r_buf;
  logic [1:0][4:0]  r_shift;
  logic [1:0]       r_full, w_full_nxt;
  logic             r_wptr, r_rptr;
  logic [IW-1:0]    r_wcnt;

  logic             w_acc_fire, w_wlast;
  logic [4:0]       w_cfg_s;
  logic             w_load, w_clear, w_free;
  logic             w_sel_buf;
  logic [IW-1:0]    w_sel_row, w_sel_col;

  // ---------------- write side ----------------
  assign acc_ready  = rst & ~r_full[r_wptr];
  assign w_acc_fire = acc_valid & acc_ready;
  assign w_wlast    = (r_wcnt == IW'(TILE-1));
  assign w_cfg_s    = (int'(cfg_shift) > ACC_W-1) ? 5'(ACC_W-1) : cfg_shift;

  // Payload storage needs no reset: the full flags gate every use.
  always_ff @(posedge clk) begin
    if (w_acc_fire) begin
      r_buf[r_wptr][r_wcnt] <= acc_data;
      if (r_wcnt == '0) r_shift[r_wptr] <= w_cfg_s;
    end
  end

  // Fill and free can hit different buffers on the same edge; both land.
  always_comb begin
    w_full_nxt = r_full;
    if (w_free) w_full_nxt[r_rptr] = 1'b0;
    if (w_acc_fire && w_wlast) w_full_nxt[r_wptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_full  <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_full  <= w_full_nxt;
      if (w_acc_fire) begin
        r_wcnt <= w_wlast ? '0 : r_wcnt + 1'b1;
        if (w_wlast) r_wptr <= ~r_wptr;
      end
      if (w_free) r_rptr <= ~r_rptr;
    end
  end

  // ---------------- read FSM ----------------
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_free      = 1'b0;
    w_sel_buf   = r_rptr;
    w_sel_row   = '0;
    w_sel_col   = '0;
    case (r_state)
      S_IDLE: begin
        if (r_full[r_rptr]) begin
          w_state_nxt = S_EMIT;
          w_load      = 1'b1;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (out_last) begin
            w_free = 1'b1;
            // Other tile already waiting: chain straight into its (0,0).
            if (r_full[~r_rptr]) begin
              w_load    = 1'b1;
              w_sel_buf = ~r_rptr;
            end else begin
              w_state_nxt = S_IDLE;
              w_clear     = 1'b1;
            end
          end else begin
            w_load = 1'b1;
            if (out_col == IW'(TILE-1)) begin
              w_sel_row = out_row + 1'b1;
            end else begin
              w_sel_row = out_row;
              w_sel_col = out_col + 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- requantisation ----------------
  logic        [ACC_W-1:0] w_elem;
  logic        [4:0]       w_s;
  logic signed [ACC_W:0]   w_x, w_rnd, w_sum, w_y;
  logic        [OUT_W-1:0] w_q;
  logic                    w_qsat;

  assign w_elem = r_buf[w_sel_buf][w_sel_row][w_sel_col];
  assign w_s    = r_shift[w_sel_buf];
  assign w_x    = {w_elem[ACC_W-1], w_elem};
  assign w_rnd  = (w_s == 5'd0) ? '0 : ((ACC_W+1)'(1) << (w_s - 5'd1));
  assign w_sum  = w_x + w_rnd;
  assign w_y    = w_sum >>> w_s;

`ifdef ACC_TILE_DRAIN_SAT_EN
  logic [ACC_W-OUT_W+1:0] w_hi;
  logic                   w_ovf;
  assign w_hi   = w_y[ACC_W:OUT_W-1];
  assign w_ovf  = ~(&w_hi | ~|w_hi);
  assign w_q    = !w_ovf    ? w_y[OUT_W-1:0] :
                  w_y[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  assign w_qsat = w_ovf;
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_y[ACC_W:OUT_W];
  assign w_q         = w_y[OUT_W-1:0];
  assign w_qsat      = 1'b0;
`endif

  // ---------------- output register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (w_load) begin
      out_valid <= 1'b1;
      out_data  <= w_q;
      out_row   <= w_sel_row;
      out_col   <= w_sel_col;
      out_last  <= (w_sel_row == IW'(TILE-1)) && (w_sel_col == IW'(TILE-1));
      out_sat   <= w_qsat;
    end else if (w_clear) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_tile_drain.sv
// Directed bench for acc_tile_drain: requant vector table, backpressure, random stall and reset sequences.
module tb_acc_tile_drain;
  localparam int TILE = 4, ACC_W = 32, OUT_W = 16, IW = 2;

  logic                  clk = 1'b0, rst = 1'b0;
  logic                  acc_valid = 1'b0, acc_ready;
  logic [TILE*ACC_W-1:0] acc_data = '0;
  logic [4:0]            cfg_shift = '0;
  logic                  out_valid, out_ready = 1'b0;
  logic [OUT_W-1:0]      out_data;
  logic [IW-1:0]         out_row, out_col;
  logic                  out_last, out_sat;

  acc_tile_drain #(.TILE(TILE), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_data(acc_data), .cfg_shift(cfg_shift), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_col(out_col), .out_last(out_last), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  typedef logic [3:0][3:0][31:0] tile_t;
  typedef struct packed {logic [15:0] d; logic [1:0] r; logic [1:0] c; logic l; logic s;} beat_t;
  typedef struct {int x; int s; logic [15:0] d; logic sat;} vec_t;

`ifdef ACC_TILE_DRAIN_SAT_EN
  localparam logic [15:0] P70K_D = 16'h7FFF, N70K_D = 16'h8000, FFFF_D = 16'h7FFF;
  localparam logic        CLIP_S = 1'b1;
`else
  localparam logic [15:0] P70K_D = 16'h1170, N70K_D = 16'hEE90, FFFF_D = 16'hFFFF;
  localparam logic        CLIP_S = 1'b0;
`endif

  beat_t exp_q[$];
  int    n_chk = 0, n_pass = 0, rows_acc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  // Reference: round-half-up shift in 64-bit arithmetic, then clip or wrap.
  function automatic beat_t mk(input int x, input int s, input int r, input int c);
    longint v, y;
    int     se;
    beat_t  b;
    se  = (s > 31) ? 31 : s;
    v   = x;
    y   = (se == 0) ? v : ((v + (longint'(1) <<< (se - 1))) >>> se);
    b.s = 1'b0;
`ifdef ACC_TILE_DRAIN_SAT_EN
    if (y > 32767) begin y = 32767; b.s = 1'b1; end
    else if (y < -32768) begin y = -32768; b.s = 1'b1; end
`endif
    b.d = y[15:0];
    b.r = r[1:0];
    b.c = c[1:0];
    b.l = (r == 3 && c == 3);
    return b;
  endfunction

  task automatic push_exp(input tile_t t, input int s);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) exp_q.push_back(mk(int'(t[r][c]), s, r, c));
  endtask

  // Called at a negedge; returns at the negedge after the row was taken.
  task automatic send_row(input logic [127:0] d, input logic [4:0] s);
    int w = 0;
    acc_valid = 1'b1; acc_data = d; cfg_shift = s;
    while (!acc_ready) begin
      if (w > 4000) begin
        n_chk++;
        $display("FAIL send_timeout: acc_ready stuck at 0, want 1");
        acc_valid = 1'b0;
        return;
      end
      @(negedge clk); w++;
    end
    @(posedge clk); rows_acc++;
    @(negedge clk);
  endtask

  task automatic send_tile(input tile_t t, input logic [4:0] s);
    for (int r = 0; r < 4; r++) send_row(t[r], (r == 0) ? s : 5'($urandom_range(0, 31)));
    acc_valid = 1'b0;
  endtask

  // Consumes n beats from exp_q; every valid cycle (stalled or not) is compared.
  task automatic drain(input int n, input bit rnd, input bit nogap);
    int    got = 0, cyc = 0;
    beat_t e, a;
    while (got < n) begin
      if (cyc > 3000 || exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL drain_timeout: beats %0d, want %0d", got, n);
        break;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (nogap && got > 0) chk("nogap", out_valid, 1);
      if (out_valid) begin
        e = exp_q[0];
        a = {out_data, out_row, out_col, out_last, out_sat};
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL beat%0d: got d=%h r=%0d c=%0d last=%b sat=%b, want d=%h r=%0d c=%0d last=%b sat=%b",
                      got, a.d, a.r, a.c, a.l, a.s, e.d, e.r, e.c, e.l, e.s);
        if (out_ready) begin void'(exp_q.pop_front()); got++; end
      end
      @(negedge clk); cyc++;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t  vt[12];
    tile_t t, ta, tb2, tc, tr1, tr2;
    int    w, s1, s2;

    vt[0]  = '{100,          0,  16'd100,  1'b0};
    vt[1]  = '{32'h00012345, 4,  16'h1234, 1'b0};
    vt[2]  = '{-9,           1,  16'hFFFC, 1'b0};
    vt[3]  = '{70000,        0,  P70K_D,   CLIP_S};
    vt[4]  = '{-70000,       0,  N70K_D,   CLIP_S};
    vt[5]  = '{-1,           1,  16'h0000, 1'b0};
    vt[6]  = '{7,            1,  16'h0004, 1'b0};
    vt[7]  = '{32'h7FFFFFFF, 31, 16'h0001, 1'b0};
    vt[8]  = '{-5,           2,  16'hFFFF, 1'b0};
    vt[9]  = '{32'h80000000, 16, 16'h8000, 1'b0};
    vt[10] = '{32'h00FFFF00, 8,  FFFF_D,   CLIP_S};
    vt[11] = '{-32768,       0,  16'h8000, 1'b0};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", acc_ready, 0);
    chk("rst_outs", {out_valid, out_data, out_row, out_col, out_last, out_sat}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", acc_ready, 1);

    // requant vector table: whole tile of one value, latency and order checked
    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          t[r][c] = vt[i].x;
          exp_q.push_back({vt[i].d, 2'(r), 2'(c), (r == 3 && c == 3), vt[i].sat});
        end
      send_tile(t, vt[i].s[4:0]);
      chk("lat_k", out_valid, 0);
      @(negedge clk);
      chk("lat_k1", out_valid, 1);
      drain(16, 1'b0, 1'b1);
      chk("idle_after", out_valid, 0);
    end

    // three tiles back-to-back under full backpressure
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ta[r][c]  = 1000 + r * 4 + c;
        tb2[r][c] = -2000 - r * 4 - c;
        tc[r][c]  = 30000 + (r * 4 + c) * 100;
      end
    exp_q.delete();
    push_exp(ta, 0); push_exp(tb2, 2); push_exp(tc, 0);
    rows_acc = 0;
    fork
      begin send_tile(ta, 0); send_tile(tb2, 2); send_tile(tc, 0); end
      begin
        w = 0;
        while (rows_acc < 8 && w < 200) begin @(negedge clk); w++; end
        repeat (4) @(negedge clk);
        chk("bp_rows", rows_acc, 8);
        chk("bp_ready", acc_ready, 0);
        chk("bp_hold", {out_valid, out_data, out_row, out_col}, {1'b1, exp_q[0].d, 4'b0});
        drain(48, 1'b0, 1'b1);
      end
    join
    chk("bp_idle", out_valid, 0);

    // random data and shifts, random out_ready
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        tr1[r][c] = $urandom();
        tr2[r][c] = $urandom_range(0, 400000) - 200000;
      end
    s1 = $urandom_range(0, 20);
    s2 = $urandom_range(0, 6);
    push_exp(tr1, s1); push_exp(tr2, s2);
    fork
      begin send_tile(tr1, 5'(s1)); send_tile(tr2, 5'(s2)); end
      drain(32, 1'b1, 1'b0);
    join

    // reset after two rows: partial tile discarded
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r][c] = 50 * (r * 4 + c) - 300;
    send_row(ta[0], 0);
    send_row(ta[1], 0);
    acc_valid = 1'b0;
    rst = 1'b0; #1;
    chk("rst1_ready", acc_ready, 0);
    chk("rst1_outs", {out_valid, out_data, out_row, out_col, out_last, out_sat}, 0);
    @(negedge clk); rst = 1'b1; @(negedge clk);
    push_exp(t, 3);
    send_tile(t, 3);
    @(negedge clk);
    chk("rst1_lat", out_valid, 1);
    drain(16, 1'b0, 1'b1);

    // reset while emitting a stalled tile
    send_tile(tb2, 1);
    repeat (3) @(negedge clk);
    chk("rst2_pre", out_valid, 1);
    rst = 1'b0; #1;
    chk("rst2_ready", acc_ready, 0);
    chk("rst2_outs", {out_valid, out_data, out_row, out_col, out_last, out_sat}, 0);
    @(negedge clk); rst = 1'b1; @(negedge clk);
    exp_q.delete();
    push_exp(tc, 1);
    send_tile(tc, 1);
    chk("rst2_lat_k", out_valid, 0);
    @(negedge clk);
    chk("rst2_lat_k1", out_valid, 1);
    drain(16, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
